// File: rtl/dummy_chain_array.sv
// CHANNELS parallel register chains, WIDTH bits by DEPTH stages, with
// selectable XOR/shift/add update, fill tracking and mode-change flush.
module dummy_chain_array #(
   parameter int CHANNELS   = 4,
   parameter int WIDTH      = 8,
   parameter int DEPTH      = 10,
   parameter int RESET_MODE = 0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic [1:0]                mode,
   input  logic [CHANNELS*WIDTH-1:0] in,
   output logic [CHANNELS*WIDTH-1:0] tails,
   output logic [WIDTH-1:0]          out_and,
   output logic [WIDTH-1:0]          out_xor,
   output logic                      out_valid,
   output logic                      busy
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);
   localparam logic [1:0] MODE_RST = 2'(RESET_MODE);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      FULL,
      FLUSH
   } state_t;

   state_t state, state_next;
   logic [1:0] cur_mode, eff_mode;
   logic [CW-1:0] cnt;
   logic mode_change, update;
   logic [WIDTH-1:0] stage [CHANNELS][DEPTH];
   logic [WIDTH-1:0] and_next, xor_next;

   // Mode 3 aliases XOR; a mode change pre-empts any stage update.
   always_comb begin
      eff_mode    = (mode == 2'd3) ? 2'd0 : mode;
      mode_change = (state != FLUSH) && (eff_mode != cur_mode);
      update      = en && (state != FLUSH) && !mode_change;
   end

   // Next-state logic for the fill/flush controller.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (mode_change)
               state_next = FLUSH;
            else if (update)
               state_next = FILL;
         end
         FILL: begin
            if (mode_change)
               state_next = FLUSH;
            else if (update && cnt == CNT_MAX - 1'b1)
               state_next = FULL;
         end
         FULL: begin
            if (mode_change)
               state_next = FLUSH;
         end
         FLUSH: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Fill counter and active mode; the flush cycle adopts the new mode.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt      <= '0;
         cur_mode <= MODE_RST;
      end else if (state == FLUSH) begin
         cnt      <= '0;
         cur_mode <= eff_mode;
      end else if (update && cnt != CNT_MAX) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Chain stages: cleared on reset/flush, advanced on update edges.
   always_ff @(posedge clk) begin
      if (rst || state == FLUSH) begin
         for (int c = 0; c < CHANNELS; c++)
            for (int i = 0; i < DEPTH; i++)
               stage[c][i] <= '0;
      end else if (update) begin
         for (int c = 0; c < CHANNELS; c++) begin
            stage[c][0] <= in[c*WIDTH +: WIDTH];
            for (int i = 1; i < DEPTH; i++) begin
               case (cur_mode)
                  2'd1:    stage[c][i] <= stage[c][i-1];
                  2'd2:    stage[c][i] <= stage[c][i] + stage[c][i-1];
                  default: stage[c][i] <= stage[c][i] ^ stage[c][i-1];
               endcase
            end
         end
      end
   end

   // Reductions across all channel tails.
   always_comb begin
      and_next = '1;
      xor_next = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         and_next = and_next & stage[c][DEPTH-1];
         xor_next = xor_next ^ stage[c][DEPTH-1];
      end
   end

   // Reduction outputs register every edge, independent of en.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_and <= '0;
         out_xor <= '0;
      end else begin
         out_and <= and_next;
         out_xor <= xor_next;
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_tail
      assign tails[c*WIDTH +: WIDTH] = stage[c][DEPTH-1];
   end

   assign out_valid = (state == FULL);
   assign busy      = (state == FLUSH);

endmodule

// File: tb/tb_dummy_chain_array.sv
// Directed bench for dummy_chain_array: three instances cover the
// default size, a 2x8x4 array and a 1x2x4 add-mode wrap case.
module tb_dummy_chain_array;

   logic clk = 1'b0;
   logic rst;

   logic        a_en;
   logic [1:0]  a_mode;
   logic [31:0] a_in, a_tails;
   logic [7:0]  a_and, a_xor;
   logic        a_valid, a_busy;

   logic        b_en;
   logic [1:0]  b_mode;
   logic [15:0] b_in, b_tails;
   logic [7:0]  b_and, b_xor;
   logic        b_valid, b_busy;

   logic        c_en;
   logic [1:0]  c_mode;
   logic [1:0]  c_in, c_tails;
   logic [1:0]  c_and, c_xor;
   logic        c_valid, c_busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dummy_chain_array u_a (
      .clk(clk), .rst(rst), .en(a_en), .mode(a_mode), .in(a_in),
      .tails(a_tails), .out_and(a_and), .out_xor(a_xor),
      .out_valid(a_valid), .busy(a_busy)
   );

   dummy_chain_array #(
      .CHANNELS(2), .WIDTH(8), .DEPTH(4), .RESET_MODE(0)
   ) u_b (
      .clk(clk), .rst(rst), .en(b_en), .mode(b_mode), .in(b_in),
      .tails(b_tails), .out_and(b_and), .out_xor(b_xor),
      .out_valid(b_valid), .busy(b_busy)
   );

   dummy_chain_array #(
      .CHANNELS(1), .WIDTH(2), .DEPTH(4), .RESET_MODE(2)
   ) u_c (
      .clk(clk), .rst(rst), .en(c_en), .mode(c_mode), .in(c_in),
      .tails(c_tails), .out_and(c_and), .out_xor(c_xor),
      .out_valid(c_valid), .busy(c_busy)
   );

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [7:0] xt_exp [5];
      logic [7:0] xx_exp [5];
      logic [7:0] ad_exp [5];
      logic [1:0] cw_exp [6];
      int n;
      xt_exp = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h01};
      xx_exp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h01};
      ad_exp = '{8'h01, 8'h01, 8'h00, 8'h01, 8'h04};
      cw_exp = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2};

      rst = 1'b1;
      a_en = 1'b1; a_mode = 2'd0; a_in = '1;
      b_en = 1'b1; b_mode = 2'd0; b_in = '1;
      c_en = 1'b1; c_mode = 2'd2; c_in = '1;
      tick();
      tick();
      check("rst_tails", a_tails, 32'h0);
      check("rst_and", {24'h0, a_and}, 32'h0);
      check("rst_xor", {24'h0, a_xor}, 32'h0);
      check("rst_valid", {31'h0, a_valid}, 32'h0);
      check("rst_busy", {31'h0, a_busy}, 32'h0);

      rst = 1'b0;
      b_en = 1'b0; b_in = '0;
      c_en = 1'b0; c_in = '0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         check($sformatf("fill_valid_%0d", k), {31'h0, a_valid},
               (k == 10) ? 32'h1 : 32'h0);
      end
      a_en = 1'b0;

      b_en = 1'b1;
      for (int e = 0; e < 5; e++) begin
         b_in = (e == 0) ? 16'h0001 : 16'h0000;
         tick();
         check($sformatf("xor_tail_%0d", e + 1), {24'h0, b_tails[7:0]},
               {24'h0, xt_exp[e]});
         check($sformatf("xor_out_%0d", e + 1), {24'h0, b_xor},
               {24'h0, xx_exp[e]});
         check($sformatf("xor_and_%0d", e + 1), {24'h0, b_and}, 32'h0);
      end
      check("xor_valid", {31'h0, b_valid}, 32'h1);

      b_mode = 2'd3; b_en = 1'b0;
      tick();
      check("m3_busy", {31'h0, b_busy}, 32'h0);
      check("m3_valid", {31'h0, b_valid}, 32'h1);
      check("m3_hold", {24'h0, b_tails[7:0]}, 32'h01);

      b_mode = 2'd1; b_en = 1'b1; b_in = 16'hFFFF;
      tick();
      check("mc_busy", {31'h0, b_busy}, 32'h1);
      check("mc_valid", {31'h0, b_valid}, 32'h0);
      check("mc_noupd", {24'h0, b_tails[7:0]}, 32'h01);
      tick();
      check("fl_busy", {31'h0, b_busy}, 32'h0);
      check("fl_tails", {16'h0, b_tails}, 32'h0);
      check("fl_valid", {31'h0, b_valid}, 32'h0);

      b_in = 16'hA5A5;
      for (int j = 1; j <= 8; j++) begin
         b_en = (j % 2 == 1);
         tick();
         n = (j + 1) / 2;
         check($sformatf("sh_tails_%0d", j), {16'h0, b_tails},
               (n >= 4) ? 32'hA5A5 : 32'h0);
         check($sformatf("sh_valid_%0d", j), {31'h0, b_valid},
               (n >= 4) ? 32'h1 : 32'h0);
      end
      check("sh_and", {24'h0, b_and}, 32'hA5);
      check("sh_xor", {24'h0, b_xor}, 32'h0);

      b_mode = 2'd2; b_in = 16'h0001; b_en = 1'b1;
      tick();
      check("ad_busy", {31'h0, b_busy}, 32'h1);
      tick();
      check("ad_flush", {16'h0, b_tails}, 32'h0);
      for (int e = 0; e < 5; e++) begin
         tick();
         if (e >= 2)
            check($sformatf("ad_tail_%0d", e + 1),
                  {24'h0, b_tails[7:0]}, {24'h0, ad_exp[e]});
      end
      check("ad_ch1", {24'h0, b_tails[15:8]}, 32'h0);
      b_en = 1'b0;

      c_en = 1'b1; c_in = 2'd1;
      for (int e = 0; e < 6; e++) begin
         tick();
         check($sformatf("wrap_tail_%0d", e + 1), {30'h0, c_tails},
               {30'h0, cw_exp[e]});
         if (e == 4) begin
            check("wrap_xor", {30'h0, c_xor}, 32'h1);
            check("wrap_and", {30'h0, c_and}, 32'h1);
         end
      end
      check("wrap_busy", {31'h0, c_busy}, 32'h0);
      c_en = 1'b0;

      rst = 1'b1;
      tick();
      rst = 1'b0; a_en = 1'b1; a_in = '1;
      tick();
      tick();
      check("mf_valid0", {31'h0, a_valid}, 32'h0);
      rst = 1'b1; a_mode = 2'd1;
      tick();
      check("mr_busy", {31'h0, a_busy}, 32'h0);
      check("mr_valid", {31'h0, a_valid}, 32'h0);
      check("mr_tails", a_tails, 32'h0);
      rst = 1'b0; a_mode = 2'd0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         if (k == 1)
            check("mr_nofl", {31'h0, a_busy}, 32'h0);
         if (k == 9)
            check("mr_valid9", {31'h0, a_valid}, 32'h0);
         if (k == 10)
            check("mr_valid10", {31'h0, a_valid}, 32'h1);
      end

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
